// File: rtl/riscv_fetch_pkg.sv
// Shared types for the instruction-fetch stage: FSM states, the fetch-buffer entry and the NOP encoding.
package riscv_fetch_pkg;

  typedef enum logic [1:0] {
    REQ   = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

  localparam logic [31:0] RVI_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'd3;
  endfunction

endpackage

// File: rtl/riscv_fetch_fifo.sv
// Fetch buffer: power-of-two FIFO of {pc, instr} entries with flush and push+pop when full.
module riscv_fetch_fifo
  import riscv_fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  fetch_entry_t             entry_in,
  input  logic                     pop,
  input  logic                     flush,
  output fetch_entry_t             head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  // A full buffer still accepts a push when the head leaves in the same cycle.
  assign do_pop  = pop & (count != '0);
  assign do_push = push & ((count != FULL) | do_pop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= entry_in;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/riscv_fetch_stage.sv
// Instruction fetch: PC, single-outstanding imem requests, fetch buffer and redirect flush.
// Optional FETCH_PERF_CNT_EN adds perf_fetch_cnt / perf_stall_cnt outputs.
module riscv_fetch_stage
  import riscv_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_out,
  output logic [31:0] instr_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int OW = CW + 1;

  fetch_state_e  state;
  logic          run;
  logic          stale;
  logic [31:0]   pc;
  logic [31:0]   req_pc;
  logic [31:0]   redir_pc;
  logic [CW-1:0] count;
  fetch_entry_t  head;
  fetch_entry_t  hold;
  logic          resp_here;
  logic          push;
  logic          pop;
  logic          fire;
  logic          issue_ok;
  logic [OW-1:0] occ;

  assign resp_here = (state == WAIT) & imem_rvalid;
  assign push      = resp_here & ~redirect_valid;
  assign pop       = instr_valid & instr_ready;

  // Occupancy at the end of this cycle; a new request is only issued if its response fits.
  assign occ      = OW'(count) + OW'(resp_here) - OW'(pop);
  assign issue_ok = run & ((state == REQ) | resp_here) & (occ < OW'(FIFO_DEPTH));

  // A request already presented on a flushed path stays asserted until acked.
  assign imem_req  = stale | issue_ok;
  assign imem_addr = pc;
  assign fire      = imem_req & imem_ack;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= REQ;
      run   <= 1'b0;
      stale <= 1'b0;
      pc    <= word_align(RESET_PC);
    end else begin
      run <= 1'b1;
      if (redirect_valid) begin
        if (fire) begin
          state <= DRAIN;
          stale <= 1'b0;
          pc    <= word_align(redirect_pc);
        end else if (imem_req) begin
          state <= REQ;
          stale <= 1'b1;
        end else if ((state != REQ) && !imem_rvalid) begin
          state <= DRAIN;
          pc    <= word_align(redirect_pc);
        end else begin
          state <= REQ;
          pc    <= word_align(redirect_pc);
        end
      end else if (stale) begin
        if (fire) begin
          state <= DRAIN;
          stale <= 1'b0;
          pc    <= redir_pc;
        end
      end else begin
        case (state)
          REQ: begin
            if (fire) begin
              state <= WAIT;
              pc    <= pc + 32'd4;
            end
          end
          WAIT: begin
            if (imem_rvalid) begin
              if (fire) begin
                state <= WAIT;
                pc    <= pc + 32'd4;
              end else begin
                state <= REQ;
              end
            end
          end
          DRAIN: begin
            if (imem_rvalid) state <= REQ;
          end
          default: state <= REQ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (fire)           req_pc   <= pc;
    if (redirect_valid) redir_pc <= word_align(redirect_pc);
  end

  riscv_fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .entry_in ('{pc: req_pc, instr: imem_rdata}),
    .pop      (pop),
    .flush    (redirect_valid),
    .head     (head),
    .count    (count)
  );

  // Last accepted entry, shown while the buffer is empty.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold <= '{pc: 32'h0, instr: RVI_NOP};
    end else if (pop) begin
      hold <= head;
    end
  end

  assign instr_valid = (count != '0);
  assign instr_out   = instr_valid ? head.instr : hold.instr;
  assign instr_pc    = instr_valid ? head.pc    : hold.pc;

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (push)                       perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (instr_valid && !instr_ready) perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_riscv_fetch_stage.sv
// Self-checking bench for riscv_fetch_stage: memory responder plus an in-order PC-stream reference.
module tb_riscv_fetch_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr_out;
  logic [31:0] instr_pc;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  always #5 clk = ~clk;

  riscv_fetch_stage #(
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (2)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_out      (instr_out),
    .instr_pc       (instr_pc)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  int n_chk = 0;
  int n_pass = 0;

  // Memory responder and reference model state.
  int          cyc;
  int          out_cnt;
  logic [31:0] resp_addr;
  int          resp_due;
  int          lat_lo = 1;
  int          lat_hi = 1;
  int          ack_pct = 100;
  logic [31:0] exp_pc;
  bit          exp_invalid;
  bit          prev_hold;
  logic [31:0] prev_addr;
  logic [31:0] acc_pc [$];
  logic [31:0] acc_ins [$];
  int          acc_cyc [$];
  logic [31:0] ack_addr [$];
  int          ack_cyc [$];

  function automatic logic [31:0] memf(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'hDEAD_BEEF;
      32'h0000_0004: return 32'h1234_5678;
      32'h0000_0008: return 32'hFEDC_BA98;
      default:       return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
    endcase
  endfunction

  task automatic clear_logs();
    acc_pc.delete();
    acc_ins.delete();
    acc_cyc.delete();
    ack_addr.delete();
    ack_cyc.delete();
  endtask

  // One clock: drive inputs at the falling edge, sample after settling, update the model.
  task automatic cycle(input bit rdy, input bit redir, input logic [31:0] rpc);
    @(negedge clk);
    cyc++;
    instr_ready    = rdy;
    imem_ack       = ($urandom_range(99) < ack_pct);
    redirect_valid = redir;
    redirect_pc    = rpc;
    if (out_cnt == 1 && cyc >= resp_due) begin
      imem_rvalid = 1'b1;
      imem_rdata  = memf(resp_addr);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
    #1;
    if (prev_hold) begin
      n_chk++;
      if (imem_req !== 1'b1 || imem_addr !== prev_addr)
        $display("FAIL req_stable: got req=%b addr=%h expected req=1 addr=%h", imem_req, imem_addr, prev_addr);
      else n_pass++;
    end
    if (exp_invalid) begin
      n_chk++;
      if (instr_valid !== 1'b0)
        $display("FAIL valid_after_redirect: got %b expected 0", instr_valid);
      else n_pass++;
    end
    if (instr_valid === 1'b1 && rdy) begin
      n_chk++;
      if (instr_pc !== exp_pc)
        $display("FAIL stream_pc: got %h expected %h", instr_pc, exp_pc);
      else n_pass++;
      n_chk++;
      if (instr_out !== memf(exp_pc))
        $display("FAIL stream_instr: got %h expected %h (pc %h)", instr_out, memf(exp_pc), exp_pc);
      else n_pass++;
      acc_pc.push_back(instr_pc);
      acc_ins.push_back(instr_out);
      acc_cyc.push_back(cyc);
      exp_pc = exp_pc + 32'd4;
    end
    if (imem_rvalid) out_cnt = 0;
    if (imem_req === 1'b1 && imem_ack) begin
      n_chk++;
      if (out_cnt != 0 || imem_addr[1:0] !== 2'b00)
        $display("FAIL one_outstanding: got outstanding=%0d addr=%h expected 0 and aligned", out_cnt, imem_addr);
      else n_pass++;
      out_cnt   = 1;
      resp_addr = imem_addr;
      resp_due  = cyc + $urandom_range(lat_hi, lat_lo);
      ack_addr.push_back(imem_addr);
      ack_cyc.push_back(cyc);
    end
    prev_hold   = (imem_req === 1'b1) && !imem_ack;
    prev_addr   = imem_addr;
    exp_invalid = redir;
    if (redir) exp_pc = rpc & ~32'd3;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    imem_ack = 1'b0;
    imem_rvalid = 1'b0;
    redirect_valid = 1'b0;
    instr_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    cyc = 0;
    out_cnt = 0;
    prev_hold = 1'b0;
    exp_invalid = 1'b0;
    exp_pc = 32'h0;
    clear_logs();
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b0;
    imem_ack = 1'b0;
    imem_rvalid = 1'b0;
    instr_ready = 1'b0;
    #1;
    n_chk++;
    if (imem_req !== 1'b0) $display("FAIL reset_req: got %b expected 0", imem_req); else n_pass++;
    n_chk++;
    if (instr_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", instr_valid); else n_pass++;
    n_chk++;
    if (instr_out !== 32'h0000_0013) $display("FAIL reset_instr: got %h expected 00000013", instr_out); else n_pass++;
    n_chk++;
    if (instr_pc !== 32'h0) $display("FAIL reset_pc: got %h expected 00000000", instr_pc); else n_pass++;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #1;
    n_chk++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0)
      $display("FAIL release_req: got req=%b addr=%h expected req=1 addr=00000000", imem_req, imem_addr);
    else n_pass++;
    n_chk++;
    if (instr_valid !== 1'b0) $display("FAIL release_valid: got %b expected 0", instr_valid); else n_pass++;
  endtask

  task automatic test_stream();
    do_reset();
    ack_pct = 100; lat_lo = 1; lat_hi = 1;
    repeat (8) cycle(1'b1, 1'b0, 32'h0);
    n_chk++;
    if (acc_pc.size() < 3) begin
      $display("FAIL stream_count: got %0d expected >=3", acc_pc.size());
    end else begin
      n_pass++;
      n_chk++;
      if (acc_pc[0] !== 32'h0 || acc_pc[1] !== 32'h4 || acc_pc[2] !== 32'h8)
        $display("FAIL stream_order: got %h %h %h expected 0 4 8", acc_pc[0], acc_pc[1], acc_pc[2]);
      else n_pass++;
      n_chk++;
      if (acc_ins[0] !== 32'hDEAD_BEEF || acc_ins[1] !== 32'h1234_5678 || acc_ins[2] !== 32'hFEDC_BA98)
        $display("FAIL stream_words: got %h %h %h expected deadbeef 12345678 fedcba98", acc_ins[0], acc_ins[1], acc_ins[2]);
      else n_pass++;
      n_chk++;
      if (acc_cyc[0] != 3 || acc_cyc[1] != 4 || acc_cyc[2] != 5)
        $display("FAIL stream_timing: got cycles %0d %0d %0d expected 3 4 5", acc_cyc[0], acc_cyc[1], acc_cyc[2]);
      else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    ack_pct = 100; lat_lo = 1; lat_hi = 1;
    repeat (10) cycle(1'b0, 1'b0, 32'h0);
    n_chk++;
    if (ack_addr.size() != 2) $display("FAIL bp_requests: got %0d expected 2", ack_addr.size()); else n_pass++;
    n_chk++;
    if (imem_req !== 1'b0) $display("FAIL bp_req_low: got %b expected 0", imem_req); else n_pass++;
    n_chk++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'h0)
      $display("FAIL bp_head: got valid=%b pc=%h expected valid=1 pc=00000000", instr_valid, instr_pc);
    else n_pass++;
    clear_logs();
    repeat (12) cycle(1'b1, 1'b0, 32'h0);
    n_chk++;
    if (acc_pc.size() != 12) $display("FAIL bp_resume_rate: got %0d expected 12", acc_pc.size()); else n_pass++;
    n_chk++;
    if (acc_pc.size() == 0 || acc_pc[acc_pc.size()-1] !== 32'h2C)
      $display("FAIL bp_resume_last: got %0d words expected last pc 0000002c", acc_pc.size());
    else n_pass++;
  endtask

  task automatic test_redirect_wait();
    int stale_due;
    do_reset();
    ack_pct = 100; lat_lo = 3; lat_hi = 3;
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 1'b0, 32'h0);
      if (out_cnt == 1 && resp_due > cyc + 1) break;
    end
    stale_due = resp_due;
    clear_logs();
    cycle(1'b1, 1'b1, 32'h0000_0103);
    for (int i = 0; i < 30 && acc_pc.size() == 0; i++) cycle(1'b1, 1'b0, 32'h0);
    n_chk++;
    if (acc_pc.size() == 0 || acc_pc[0] !== 32'h100)
      $display("FAIL redir_wait_pc: got %0d words expected first pc 00000100", acc_pc.size());
    else n_pass++;
    n_chk++;
    if (ack_addr.size() == 0 || ack_addr[0] !== 32'h100 || ack_cyc[0] < stale_due)
      $display("FAIL redir_wait_fetch: got %0d requests expected first addr 00000100 at/after cycle %0d", ack_addr.size(), stale_due);
    else n_pass++;
  endtask

  task automatic test_redirect_rvalid_full();
    do_reset();
    ack_pct = 100; lat_lo = 1; lat_hi = 1;
    repeat (2) cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 32'h0000_0200);
    clear_logs();
    for (int i = 0; i < 20 && acc_pc.size() == 0; i++) cycle(1'b1, 1'b0, 32'h0);
    n_chk++;
    if (acc_pc.size() == 0 || acc_pc[0] !== 32'h200)
      $display("FAIL redir_rvalid_pc: got %0d words expected first pc 00000200", acc_pc.size());
    else n_pass++;
    repeat (6) cycle(1'b0, 1'b0, 32'h0);
    n_chk++;
    if (instr_valid !== 1'b1 || imem_req !== 1'b0)
      $display("FAIL redir_full_state: got valid=%b req=%b expected valid=1 req=0", instr_valid, imem_req);
    else n_pass++;
    cycle(1'b1, 1'b1, 32'h0000_0300);
    clear_logs();
    for (int i = 0; i < 20 && acc_pc.size() == 0; i++) cycle(1'b1, 1'b0, 32'h0);
    n_chk++;
    if (acc_pc.size() == 0 || acc_pc[0] !== 32'h300)
      $display("FAIL redir_full_pc: got %0d words expected first pc 00000300", acc_pc.size());
    else n_pass++;
  endtask

  task automatic test_wrap();
    do_reset();
    ack_pct = 100; lat_lo = 1; lat_hi = 1;
    cycle(1'b1, 1'b1, 32'hFFFF_FFF9);
    clear_logs();
    for (int i = 0; i < 20 && acc_pc.size() < 3; i++) cycle(1'b1, 1'b0, 32'h0);
    n_chk++;
    if (acc_pc.size() < 3 || acc_pc[0] !== 32'hFFFF_FFF8 || acc_pc[1] !== 32'hFFFF_FFFC || acc_pc[2] !== 32'h0)
      $display("FAIL pc_wrap: got %0d words expected fffffff8 fffffffc 00000000", acc_pc.size());
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    bit found;
    do_reset();
    ack_pct = 100; lat_lo = 3; lat_hi = 3;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      cycle(1'b1, 1'b0, 32'h0);
      if (acc_pc.size() >= 2 && out_cnt == 1 && resp_due > cyc + 1) begin
        found = 1'b1;
        break;
      end
    end
    n_chk++;
    if (!found) $display("FAIL mid_setup: got no WAIT window expected one within 40 cycles"); else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    imem_ack = 1'b0;
    imem_rvalid = 1'b0;
    #1;
    n_chk++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b0 || instr_out !== 32'h0000_0013 || instr_pc !== 32'h0)
      $display("FAIL mid_reset_outputs: got req=%b valid=%b instr=%h pc=%h expected 0 0 00000013 00000000",
               imem_req, instr_valid, instr_out, instr_pc);
    else n_pass++;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    imem_ack = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata = 32'hBAD0_BAD0;
    instr_ready = 1'b1;
    #1;
    n_chk++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0)
      $display("FAIL mid_restart: got req=%b addr=%h expected req=1 addr=00000000", imem_req, imem_addr);
    else n_pass++;
    prev_hold = (imem_req === 1'b1);
    prev_addr = imem_addr;
    cyc = 0;
    out_cnt = 0;
    exp_pc = 32'h0;
    exp_invalid = 1'b0;
    clear_logs();
    lat_lo = 1; lat_hi = 1;
    for (int i = 0; i < 20 && acc_pc.size() == 0; i++) cycle(1'b1, 1'b0, 32'h0);
    n_chk++;
    if (acc_pc.size() == 0 || acc_pc[0] !== 32'h0 || acc_ins[0] !== 32'hDEAD_BEEF)
      $display("FAIL mid_first_word: got %0d words expected pc 00000000 instr deadbeef", acc_pc.size());
    else n_pass++;
  endtask

  task automatic test_random();
    logic [31:0] rpc;
    bit          redir;
    do_reset();
    ack_pct = 60; lat_lo = 1; lat_hi = 3;
    for (int i = 0; i < 600; i++) begin
      redir = ($urandom_range(99) < 3);
      if ($urandom_range(3) == 0) rpc = 32'hFFFF_FFE0 | ($urandom & 32'h1F);
      else                        rpc = $urandom & 32'h3FFF;
      cycle($urandom_range(99) < 70, redir, rpc);
    end
    n_chk++;
    if (acc_pc.size() < 20) $display("FAIL random_progress: got %0d words expected >=20", acc_pc.size()); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_wait();
    test_redirect_rvalid_full();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
